buspirate_top: RTL and testbench

FPGA core of the Bus Pirate I/O engine. An MCU writes configuration registers and a 16-bit command FIFO through an asynchronous parallel memory-controller bus. A small sequencer drains the FIFO and drives the BP_PINS I/O buffer controls. Logic-analyzer SRAM and latch ports are present and held idle in this revision.

---
 rtl/buspirate_pkg.sv | 22 ++
 rtl/buspirate_if.sv | 13 +
 rtl/bp_cmd_fifo.sv | 58 +++++
 rtl/buspirate_top.sv | 213 +++++++++++++++++++++
 tb/tb_buspirate_top.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/buspirate_pkg.sv
// Shared constants for the Bus Pirate I/O engine: register map, command
// opcodes and the sequencer state encoding.
package buspirate_pkg;

  localparam logic [5:0] REG_PIN_MODE  = 6'h00;
  localparam logic [5:0] REG_PIN_LEVEL = 6'h01;
  localparam logic [5:0] REG_PIN_IN    = 6'h02;
  localparam logic [5:0] REG_CTRL      = 6'h03;
  localparam logic [5:0] REG_FIFO_STAT = 6'h04;
  localparam logic [5:0] REG_FIFO_PUSH = 6'h07;

  localparam int         CMD_PIN_BIT = 15;
  localparam logic [7:0] OP_DELAY    = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_HOLD
  } seq_state_e;

endpackage

// File: rtl/buspirate_if.sv
// MCU asynchronous memory-controller strobes and address; the data bus itself
// is a top-level inout so tristate resolution stays at the pad boundary.
interface buspirate_if #(
  parameter int ADD_WIDTH = 6
);
  logic                 mc_oe;
  logic                 mc_ce;
  logic                 mc_we;
  logic [ADD_WIDTH-1:0] mc_add;

  modport master (output mc_oe, mc_ce, mc_we, mc_add);
  modport slave  (input  mc_oe, mc_ce, mc_we, mc_add);
endinterface

// File: rtl/bp_cmd_fifo.sv
// Synchronous command FIFO with registered read data, saturating count and
// power-of-two wrapping pointers.
module bp_cmd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: storage has no reset; only pointers and count define validity, and
  // leaving the array unreset lets it map onto block RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        pop_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/buspirate_top.sv
// Bus Pirate I/O engine: MCU register bus, command FIFO, pin sequencer and
// I/O buffer controls. Logic-analyzer ports are parked idle.
module buspirate_top
  import buspirate_pkg::*;
#(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int LA_WIDTH      = 8,
  parameter int LA_CHIPS      = 2,
  parameter int BP_PINS       = 5,
  parameter int FIFO_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 256
) (
  input  logic                     clock,
  input  logic                     reset,
  inout  wire  [BP_PINS-1:0]       bpio_io,
  output logic [BP_PINS-1:0]       bpio_dir,
  output logic [BP_PINS-1:0]       bpio_od,
  output logic [LA_CHIPS-1:0]      sram_clock,
  output logic [LA_CHIPS-1:0]      sram_cs,
  inout  wire  [LA_WIDTH-1:0]      sram_sio,
  output logic                     lat_oe,
  input  logic [LA_WIDTH-1:0]      lat,
  input  logic                     mcu_clock,
  input  logic                     mcu_mosi,
  output logic                     mcu_miso,
  buspirate_if.slave               mc,
  inout  wire  [MC_DATA_WIDTH-1:0] mc_data,
  output logic                     bp_active
);

  function automatic logic [7:0] pad8(input logic [BP_PINS-1:0] v);
    pad8 = '0;
    pad8[BP_PINS-1:0] = v;
  endfunction

  logic [1:0]               ce_sync;
  logic [1:0]               we_sync;
  logic                     we_prev;
  logic                     wr_fire;
  logic [BP_PINS-1:0]       od, oe, dir, level;
  logic [BP_PINS-1:0]       pin_sync [2];
  logic                     pause;
  logic [MC_DATA_WIDTH-1:0] rd_mux;

  logic                     fifo_push;
  logic                     fifo_pop;
  logic [FIFO_WIDTH-1:0]    cmd_word;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  seq_state_e               state, state_next;
  logic [7:0]               hold_cnt;
  logic [7:0]               exec_hold;
  logic                     seq_level_we;
  logic                     fetch_ok;
  logic                     unused_inputs;

  assign sram_clock    = '0;
  assign sram_cs       = '1;
  assign sram_sio      = 'z;
  assign lat_oe        = 1'b1;
  assign mcu_miso      = 1'b0;
  assign unused_inputs = ^{lat, mcu_clock, mcu_mosi, sram_sio};

  // Strobes idle high, so the synchronizers reset to 1 to avoid a phantom edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ce_sync     <= '1;
      we_sync     <= '1;
      we_prev     <= 1'b1;
      pin_sync[0] <= '0;
      pin_sync[1] <= '0;
    end else begin
      ce_sync     <= {ce_sync[0], mc.mc_ce};
      we_sync     <= {we_sync[0], mc.mc_we};
      we_prev     <= we_sync[1];
      pin_sync[0] <= bpio_io;
      pin_sync[1] <= pin_sync[0];
    end
  end

  assign wr_fire   = we_prev && !we_sync[1] && !ce_sync[1];
  assign fifo_push = wr_fire && (mc.mc_add == REG_FIFO_PUSH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      od    <= '0;
      oe    <= '0;
      dir   <= '0;
      pause <= 1'b0;
    end else if (wr_fire) begin
      case (mc.mc_add)
        REG_PIN_MODE: begin
          od <= mc_data[8 +: BP_PINS];
          oe <= mc_data[0 +: BP_PINS];
        end
        REG_PIN_LEVEL: dir   <= mc_data[0 +: BP_PINS];
        REG_CTRL:      pause <= mc_data[7];
        default: ;
      endcase
    end
  end

  // Sequencer pin commands take priority over a coincident bus write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level <= '0;
    end else if (seq_level_we) begin
      level <= cmd_word[BP_PINS-1:0];
    end else if (wr_fire && (mc.mc_add == REG_PIN_LEVEL)) begin
      level <= mc_data[8 +: BP_PINS];
    end
  end

  bp_cmd_fifo #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (mc_data),
    .pop       (fifo_pop),
    .pop_data  (cmd_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign fetch_ok  = !fifo_empty && !pause;
  assign bp_active = (state != ST_IDLE) || fetch_ok;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_EXEC)      hold_cnt <= exec_hold;
      else if (state == ST_HOLD) hold_cnt <= hold_cnt - 8'd1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    fifo_pop     = 1'b0;
    seq_level_we = 1'b0;
    exec_hold    = '0;
    case (state)
      ST_IDLE: begin
        if (fetch_ok) begin
          fifo_pop   = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: state_next = ST_EXEC;
      ST_EXEC: begin
        if (cmd_word[CMD_PIN_BIT]) begin
          seq_level_we = 1'b1;
          exec_hold    = {1'b0, cmd_word[14:8]};
        end else if (cmd_word[15:8] == OP_DELAY) begin
          exec_hold = cmd_word[7:0];
        end
        if (exec_hold != '0) begin
          state_next = ST_HOLD;
        end else if (fetch_ok) begin
          fifo_pop   = 1'b1;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_cnt <= 8'd1) begin
          if (fetch_ok) begin
            fifo_pop   = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Open-drain pins only actively drive low; a high level releases the buffer.
  assign bpio_dir = (oe & dir) & ~(od & level);
  assign bpio_od  = od;

  for (genvar i = 0; i < BP_PINS; i++) begin : g_pin
    assign bpio_io[i] = bpio_dir[i] ? level[i] : 1'bz;
  end

  always_comb begin
    rd_mux = '0;
    case (mc.mc_add)
      REG_PIN_MODE:  rd_mux = {pad8(od), pad8(oe)};
      REG_PIN_LEVEL: rd_mux = {pad8(level), pad8(dir)};
      REG_PIN_IN:    rd_mux = {8'h00, pad8(pin_sync[1])};
      REG_CTRL:      rd_mux = {8'h00, pause, 7'h00};
      REG_FIFO_STAT: rd_mux = {fifo_full, fifo_empty, 14'(fifo_count)};
      default:       rd_mux = '0;
    endcase
  end

  assign mc_data = (!mc.mc_ce && !mc.mc_oe) ? rd_mux : 'z;

endmodule

// File: tb/tb_buspirate_top.sv
// Directed bench for buspirate_top: register access, FIFO draining, pin drive
// modes, FIFO overflow and asynchronous reset during a command.
module tb_buspirate_top;

  logic        clock = 1'b0;
  logic        reset;
  wire  [4:0]  bpio_io;
  logic [4:0]  bpio_dir;
  logic [4:0]  bpio_od;
  logic [1:0]  sram_clock;
  logic [1:0]  sram_cs;
  wire  [7:0]  sram_sio;
  logic        lat_oe;
  logic [7:0]  lat;
  logic        mcu_clock;
  logic        mcu_mosi;
  logic        mcu_miso;
  wire  [15:0] mc_data;
  logic [15:0] mc_wdata;
  logic        mc_drv;
  logic        bp_active;

  int tests_run    = 0;
  int tests_failed = 0;

  buspirate_if bus ();

  assign mc_data = mc_drv ? mc_wdata : 16'bz;

  always #5 clock = ~clock;

  buspirate_top dut (
    .clock      (clock),
    .reset      (reset),
    .bpio_io    (bpio_io),
    .bpio_dir   (bpio_dir),
    .bpio_od    (bpio_od),
    .sram_clock (sram_clock),
    .sram_cs    (sram_cs),
    .sram_sio   (sram_sio),
    .lat_oe     (lat_oe),
    .lat        (lat),
    .mcu_clock  (mcu_clock),
    .mcu_mosi   (mcu_mosi),
    .mcu_miso   (mcu_miso),
    .mc         (bus.slave),
    .mc_data    (mc_data),
    .bp_active  (bp_active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clock);
    bus.mc_add = a;
    mc_wdata   = d;
    mc_drv     = 1'b1;
    bus.mc_ce  = 1'b0;
    bus.mc_we  = 1'b0;
    repeat (4) @(negedge clock);
    bus.mc_we  = 1'b1;
    bus.mc_ce  = 1'b1;
    mc_drv     = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [15:0] d);
    @(negedge clock);
    bus.mc_add = a;
    bus.mc_ce  = 1'b0;
    bus.mc_oe  = 1'b0;
    #1;
    d = mc_data;
    bus.mc_oe  = 1'b1;
    bus.mc_ce  = 1'b1;
  endtask

  initial begin
    logic [15:0] rd;
    int          n;

    reset      = 1'b0;
    bus.mc_ce  = 1'b1;
    bus.mc_oe  = 1'b1;
    bus.mc_we  = 1'b1;
    bus.mc_add = '0;
    mc_drv     = 1'b0;
    mc_wdata   = '0;
    lat        = '0;
    mcu_clock  = 1'b0;
    mcu_mosi   = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Reset state
    check("reset_dir", 32'(bpio_dir), 32'h0);
    check("reset_od", 32'(bpio_od), 32'h0);
    check("reset_active", 32'(bp_active), 32'h0);
    check("idle_ports", 32'({sram_clock, sram_cs, lat_oe, mcu_miso}), 32'b00_11_1_0);
    bus_read(6'h04, rd);
    check("reset_fifo_stat", 32'(rd), 32'h4000);

    // Pin mode and level
    bus_write(6'h00, 16'h001F);
    bus_write(6'h01, 16'h1F04);
    check("drive_dir", 32'(bpio_dir), 32'b00100);
    check("drive_pin2_high", 32'(bpio_io[2]), 32'h1);
    bus_read(6'h01, rd);
    check("read_level_dir", 32'(rd), 32'h1F04);
    bus_read(6'h00, rd);
    check("read_od_oe", 32'(rd), 32'h001F);

    // Paused: commands queue but do not run
    bus_write(6'h03, 16'h0080);
    bus_write(6'h07, 16'h81FF);
    bus_write(6'h07, 16'h0805);
    bus_write(6'h07, 16'h8100);
    bus_read(6'h04, rd);
    check("paused_count3", 32'(rd), 32'h0003);
    check("paused_inactive", 32'(bp_active), 32'h0);
    check("paused_pin2_held", 32'(bpio_io[2]), 32'h1);
    bus_read(6'h03, rd);
    check("read_pause", 32'(rd), 32'h0080);

    // Resume: drain the three commands
    bus_write(6'h03, 16'h0000);
    check("resume_active", 32'(bp_active), 32'h1);
    n = 0;
    while (bpio_io[2] !== 1'b0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("pin2_low_after_delay", 32'(n >= 5 && n < 60), 32'h1);
    n = 0;
    while (bp_active !== 1'b0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("drain_inactive", 32'(bp_active), 32'h0);
    bus_read(6'h04, rd);
    check("drain_fifo_empty", 32'(rd), 32'h4000);
    bus_read(6'h01, rd);
    check("seq_level_readback", 32'(rd), 32'h0004);

    // Open-drain on pin2
    bus_write(6'h00, 16'h041F);
    check("od_low_dir", 32'(bpio_dir), 32'b00100);
    check("od_low_od", 32'(bpio_od), 32'b00100);
    check("od_low_pin", 32'(bpio_io[2]), 32'h0);
    bus_write(6'h01, 16'h0404);
    check("od_high_dir", 32'(bpio_dir), 32'b00000);
    check("od_high_od", 32'(bpio_od), 32'b00100);

    bus_read(6'h05, rd);
    check("unmapped_read", 32'(rd), 32'h0000);
    bus_read(6'h07, rd);
    check("push_reg_read", 32'(rd), 32'h0000);

    // Overflow: 257 pushes into a 256-deep FIFO while paused
    bus_write(6'h03, 16'h0080);
    for (int i = 0; i < 257; i++) bus_write(6'h07, 16'h08FF);
    bus_read(6'h04, rd);
    check("full_stat", 32'(rd), 32'h8100);
    check("full_paused_inactive", 32'(bp_active), 32'h0);

    // Reset during a long delay command
    bus_write(6'h03, 16'h0000);
    check("long_cmd_active", 32'(bp_active), 32'h1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midcmd_reset_active", 32'(bp_active), 32'h0);
    check("midcmd_reset_dir", 32'(bpio_dir), 32'h0);
    check("midcmd_reset_od", 32'(bpio_od), 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    bus_read(6'h04, rd);
    check("post_reset_fifo", 32'(rd), 32'h4000);
    bus_read(6'h00, rd);
    check("post_reset_mode", 32'(rd), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
